// File: rtl/a2d_pkg.sv
`default_nettype none
//============================================================================
// Module   : a2d_pkg
// Brief    : Shared state encoding, SPI timing points and command-word helper
//            for the A2D SPI master.
// Revision : 1.0 - initial release
//============================================================================
package a2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER1 = 2'd1,
    PAUSE = 2'd2,
    XFER2 = 2'd3
  } a2d_state_t;

  // Divider preload at SS_n fall: 9 clk of front porch before the first SCLK fall
  localparam logic [4:0] FP_LOAD    = 5'b10111;
  // SS_n-high gap between the two transactions of one conversion
  localparam int         PAUSE_CLKS = 32;
  // Divider value in which MISO is captured (one clk before SCLK rises)
  localparam logic [4:0] SAMPLE_PT  = 5'b01111;
  // Divider value in which the shift register advances (one clk before SCLK falls)
  localparam logic [4:0] SHIFT_PT   = 5'b11111;

  // A2D control word: channel select sits in bits [13:11]
  function automatic logic [15:0] cmd_word(input logic [2:0] chnnl);
    return {2'b00, chnnl, 11'h000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_intf_spi_xfer16.sv
`default_nettype none
//============================================================================
// Module   : spi_xfer16
// Brief    : Single 16-bit SPI transaction engine. SCLK = clk/32, idles high.
//            done strobes in the last SS_n-low cycle; rd_data carries the
//            completed word during that strobe.
// Revision : 1.0 - initial release
//============================================================================
module spi_xfer16
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  logic        r_ss_n;
  logic [4:0]  r_sclk_div;
  logic [15:0] r_shft_reg;
  logic        r_sample;
  logic        r_sampled;
  logic [3:0]  r_bit_cnt;

  logic        w_shift;
  logic        w_last;

  // The divider also reads 11111 before the first sample; gating on r_sampled
  // skips that spurious shift so exactly 16 shifts occur.
  assign w_shift = !r_ss_n && (r_sclk_div == SHIFT_PT) && r_sampled;
  assign w_last  = w_shift && (r_bit_cnt == 4'd15);

  // Framing: drop SS_n on wrt, run the divider while low, release after shift 16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n     <= 1'b1;
      r_sclk_div <= SHIFT_PT;
    end else if (r_ss_n) begin
      if (wrt) begin
        r_ss_n     <= 1'b0;
        r_sclk_div <= FP_LOAD;
      end else begin
        r_sclk_div <= SHIFT_PT;
      end
    end else if (w_last) begin
      // Hold the divider so the final shift does not produce an SCLK fall
      r_ss_n     <= 1'b1;
      r_sclk_div <= SHIFT_PT;
    end else begin
      r_sclk_div <= r_sclk_div + 5'd1;
    end
  end

  // MISO capture just before each SCLK rise, and shift counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample  <= 1'b0;
      r_sampled <= 1'b0;
      r_bit_cnt <= 4'd0;
    end else if (r_ss_n) begin
      if (wrt) begin
        r_sampled <= 1'b0;
        r_bit_cnt <= 4'd0;
      end
    end else begin
      if (r_sclk_div == SAMPLE_PT) begin
        r_sample  <= MISO;
        r_sampled <= 1'b1;
      end
      if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  // Shift register: command out on MOSI, sampled MISO in at the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shft_reg <= 16'h0000;
    end else if (r_ss_n && wrt) begin
      r_shft_reg <= cmd;
    end else if (w_shift) begin
      r_shft_reg <= {r_shft_reg[14:0], r_sample};
    end
  end

  assign SS_n    = r_ss_n;
  assign SCLK    = r_sclk_div[4];
  assign MOSI    = r_shft_reg[15];
  assign done    = w_last;
  // The word as it will look after the final shift, so the caller can
  // capture it on the same edge that raises SS_n.
  assign rd_data = {r_shft_reg[14:0], r_sample};

endmodule
`default_nettype wire

// File: rtl/a2d_intf.sv
`default_nettype none
//============================================================================
// Module   : a2d_intf
// Brief    : SPI master to an 8-channel 12-bit A2D. strt_cnv latches chnnl,
//            runs the SPI transactions and returns the result on res with
//            cnv_cmplt held high until the next accepted request.
// Config   : A2D_SINGLE_XFER_EN - one transaction per conversion; result is
//            for the previously requested channel. Undefined: two
//            transactions, result for the current channel.
// Revision : 1.0 - initial release
//============================================================================
module a2d_intf
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int PAUSE_W = $clog2(PAUSE_CLKS);

  a2d_state_t         r_state;
  a2d_state_t         w_next_state;

  logic [2:0]         r_chnnl_q;
  logic               r_wrt;
  logic [PAUSE_W-1:0] r_pause_cnt;
  logic [11:0]        r_res;
  logic               r_cnv_cmplt;

  logic               w_accept;
  logic               w_start;
  logic               w_capture;
  logic               w_pause_ld;
  logic               w_done;
  logic [15:0]        w_rd_data;
  logic [15:0]        w_cmd;
  logic               w_unused_rd_hi;

  // Command is rebuilt from the latched channel for every transaction
  assign w_cmd = cmd_word(r_chnnl_q);

  // The A2D's top nibble carries no conversion data
  assign w_unused_rd_hi = &{1'b0, w_rd_data[15:12]};

  spi_xfer16 u_xfer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (r_wrt),
    .cmd     (w_cmd),
    .MISO    (MISO),
    .done    (w_done),
    .rd_data (w_rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Conversion sequencing; requests outside IDLE are dropped
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    w_pause_ld   = 1'b0;
    case (r_state)
      IDLE: begin
        if (strt_cnv) begin
          w_accept     = 1'b1;
          w_start      = 1'b1;
          w_next_state = XFER1;
        end
      end
      XFER1: begin
        if (w_done) begin
`ifdef A2D_SINGLE_XFER_EN
          w_capture    = 1'b1;
          w_next_state = IDLE;
`else
          w_pause_ld   = 1'b1;
          w_next_state = PAUSE;
`endif
        end
      end
      PAUSE: begin
        // wrt is registered, so launch one clk before the gap ends
        if (r_pause_cnt == '0) begin
          w_start      = 1'b1;
          w_next_state = XFER2;
        end
      end
      XFER2: begin
        if (w_done) begin
          w_capture    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Channel latch, transaction launch, pause timer, result and completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chnnl_q   <= 3'd0;
      r_wrt       <= 1'b0;
      r_pause_cnt <= '0;
      r_res       <= 12'h000;
      r_cnv_cmplt <= 1'b0;
    end else begin
      r_wrt <= w_start;
      if (w_accept) begin
        r_chnnl_q   <= chnnl;
        r_cnv_cmplt <= 1'b0;
      end
      // Gap counts from the clk after SS_n rises; done cycle and launch
      // cycle account for the remaining two clk.
      if (w_pause_ld) begin
        r_pause_cnt <= PAUSE_W'(PAUSE_CLKS - 2);
      end else if (r_pause_cnt != '0) begin
        r_pause_cnt <= r_pause_cnt - 1'b1;
      end
      if (w_capture) begin
        r_res       <= w_rd_data[11:0];
        r_cnv_cmplt <= 1'b1;
      end
    end
  end

  assign cnv_cmplt = r_cnv_cmplt;
  assign res       = r_res;

endmodule
`default_nettype wire

// File: tb/tb_a2d_intf.sv
`default_nettype none
//============================================================================
// Module   : tb_a2d_intf
// Brief    : Self-checking bench for a2d_intf with a behavioural A2D slave
//            and an SPI bus-timing monitor.
// Revision : 1.0 - initial release
//============================================================================
module tb_a2d_intf;

`ifdef A2D_SINGLE_XFER_EN
  localparam int LAT   = 522;
  localparam int NXFER = 1;
`else
  localparam int LAT   = 1075;
  localparam int NXFER = 2;
`endif
  localparam int SS_LOW = 521;
  localparam int GAP    = 32;
  localparam int PORCH  = 9;
  localparam int PERIOD = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  a2d_intf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- A2D slave model ----------------
  // Each channel has a 16-bit word; a transaction returns the word of the
  // channel addressed by the previous complete transaction.
  logic [15:0] chan_data [8];
  logic [2:0]  s_addr = 3'd0;
  logic [15:0] s_resp = 16'h0000;
  logic [15:0] s_cmd  = 16'h0000;
  int          s_bits = 0;

  always @(negedge SS_n) begin
    s_resp = chan_data[s_addr];
    s_cmd  = 16'h0000;
    s_bits = 0;
  end

  always @(negedge SCLK) begin
    if (!SS_n) begin
      MISO   = s_resp[15];
      s_resp = {s_resp[14:0], 1'b0};
    end
  end

  always @(posedge SCLK) begin
    if (!SS_n) begin
      s_cmd = {s_cmd[14:0], MOSI};
      s_bits++;
      if (s_bits == 16) s_addr = s_cmd[13:11];
    end
  end

  // ---------------- bus monitor ----------------
  logic [2:0]  cur_ch     = 3'd0;
  int          conv_snap  = 0;
  int          xfer_total = 0;
  logic        prev_ss    = 1'b1;
  logic        prev_sclk  = 1'b1;
  int          ss_fall_cyc = 0;
  int          ss_rise_cyc = 0;
  int          last_rise  = 0;
  int          rises      = 0;
  bit          fall_seen  = 1'b0;
  logic [15:0] mosi_word  = 16'h0000;

  always @(negedge clk) begin
    if (prev_ss && !SS_n) begin
      if (xfer_total - conv_snap == 1) check("ss_gap", 32'(cyc - ss_rise_cyc), GAP);
      ss_fall_cyc = cyc;
      rises       = 0;
      fall_seen   = 1'b0;
      mosi_word   = 16'h0000;
    end
    if (!SS_n && !prev_sclk && SCLK) begin
      rises++;
      mosi_word = {mosi_word[14:0], MOSI};
      if (rises > 1) check("sclk_period", 32'(cyc - last_rise), PERIOD);
      last_rise = cyc;
    end
    if (!SS_n && prev_sclk && !SCLK && !fall_seen) begin
      fall_seen = 1'b1;
      check("front_porch", 32'(cyc - ss_fall_cyc), PORCH);
    end
    if (!prev_ss && SS_n) begin
      // A reset-aborted transaction is not a complete one
      if (rst_n) begin
        check("ss_low_len", 32'(cyc - ss_fall_cyc), SS_LOW);
        check("sclk_rises", 32'(rises), 16);
        check("mosi_cmd", 32'(mosi_word), 32'({2'b00, cur_ch, 11'h000}));
        xfer_total++;
      end
      ss_rise_cyc = cyc;
    end
    prev_ss   = SS_n;
    prev_sclk = SCLK;
  end

  // ---------------- stimulus ----------------
  logic [2:0] prev_ch = 3'd0;

  // Call at a negedge (or just after); drives one conversion to completion.
  task automatic do_conv(input logic [2:0] ch, input int ign_at,
                         input logic [2:0] ign_ch, input int hold);
    logic [11:0] exp;
    int          t0;
    int          lat;
    bit          got;
`ifdef A2D_SINGLE_XFER_EN
    exp     = chan_data[prev_ch][11:0];
    prev_ch = ch;
`else
    exp     = chan_data[ch][11:0];
`endif
    strt_cnv = 1'b1;
    chnnl    = ch;
    @(negedge clk);
    strt_cnv  = 1'b0;
    chnnl     = 3'($urandom);
    t0        = cyc;
    cur_ch    = ch;
    conv_snap = xfer_total;
    check("cmplt_clr", 32'(cnv_cmplt), 0);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= LAT + 50 && !got; k++) begin
      if (k == ign_at) begin
        strt_cnv = 1'b1;
        chnnl    = ign_ch;
      end else begin
        strt_cnv = 1'b0;
        chnnl    = 3'($urandom);
      end
      @(negedge clk);
      if (cnv_cmplt) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    strt_cnv = 1'b0;
    check("cmplt_seen", 32'(got), 1);
    check("latency", 32'(lat), LAT);
    check("res", 32'(res), 32'(exp));
    #1;
    check("xfers", 32'(xfer_total - conv_snap), NXFER);
    repeat (hold) @(negedge clk);
    check("res_hold", 32'(res), 32'(exp));
    check("cmplt_hold", 32'(cnv_cmplt), 1);
    check("ss_idle", 32'(SS_n), 1);
  endtask

  initial begin
    logic [2:0] ch;
    bit         got;
    rst_n    = 1'b0;
    strt_cnv = 1'b0;
    chnnl    = 3'd0;
    MISO     = 1'b0;
    for (int i = 0; i < 8; i++) chan_data[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(SS_n), 1);
    check("rst_sclk", 32'(SCLK), 1);
    check("rst_mosi", 32'(MOSI), 0);
    check("rst_cmplt", 32'(cnv_cmplt), 0);
    check("rst_res", 32'(res), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Channel 3 with a known word
    chan_data[3] = 16'h0ABC;
    do_conv(3'd3, -1, 3'd0, 4);
    // Request for channel 5 mid-conversion must be ignored
    do_conv(3'd3, 300, 3'd5, 3);
    // Upper nibble must be discarded
    ch = 3'($urandom);
    chan_data[ch] = 16'hF123;
    do_conv(ch, -1, 3'd0, 10);
    // Back-to-back request in the first IDLE cycle
    do_conv(3'($urandom), -1, 3'd0, 0);
    // Request coinciding with completion is dropped
    do_conv(3'($urandom), LAT, 3'($urandom), 6);
    // Randomised conversions
    for (int i = 0; i < 5; i++) begin
      ch = 3'($urandom_range(0, 7));
      chan_data[ch] = 16'($urandom);
      do_conv(ch, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT)) : -1,
              3'($urandom), int'($urandom_range(0, 4)));
    end

    // Reset in the middle of the first transaction
    ch = 3'($urandom);
    strt_cnv = 1'b1;
    chnnl    = ch;
    @(negedge clk);
    strt_cnv  = 1'b0;
    cur_ch    = ch;
    conv_snap = xfer_total;
    repeat (399) @(negedge clk);
    check("pre_rst_ss_low", 32'(SS_n), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ss_n", 32'(SS_n), 1);
    check("arst_sclk", 32'(SCLK), 1);
    check("arst_cmplt", 32'(cnv_cmplt), 0);
    check("arst_res", 32'(res), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    repeat (LAT + 100) begin
      @(negedge clk);
      if (cnv_cmplt || !SS_n) got = 1'b1;
    end
    check("post_rst_quiet", 32'(got), 0);
    // Normal conversion after reset
    ch = 3'($urandom);
    chan_data[ch] = 16'($urandom);
    do_conv(ch, -1, 3'd0, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
